muldiv_seq: RTL and testbench

- Iterative multiply/divide sequencer owning the HI/LO register pair for the MIPS core.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO commands from the execute stage.
- Runs one radix-2 shift-add (multiply) or restoring-subtract (divide) step per cycle and holds `busy` so the controller or hazard unit stalls dependent instructions.
- Exposes HI/LO directly for MFHI/MFLO writeback.

---
 rtl/muldiv_seq_if.sv | 27 ++
 rtl/muldiv_seq.sv | 187 ++++++++++++++++++
 tb/tb_muldiv_seq.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_if.sv
// rtl/muldiv_seq_if.sv - command/result bundle between execute stage and the muldiv sequencer
//
// master: execute stage / testbench (drives start, op, srca, srcb, flush)
// slave : muldiv_seq (drives busy, done, hi, lo)
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, srca, srcb, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, srca, srcb, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative radix-2 multiply/divide sequencer owning HI/LO
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   bus.start  command valid, sampled only in IDLE
//   bus.op     0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6/7=no-op
//   bus.srca   multiplicand / dividend / MTHI-MTLO source
//   bus.srcb   multiplier / divisor
//   bus.flush  abort any in-flight operation
//   bus.busy   iterations in progress
//   bus.done   one-cycle pulse when HI/LO take a muldiv result
//   bus.hi     HI register
//   bus.lo     LO register
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_seq_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FINISH
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    // Working pair: multiply keeps {partial product, multiplier};
    // divide keeps {remainder, dividend/quotient}.
    logic [2*WIDTH-1:0] p_q, p_d;
    // Multiplicand for multiply, divisor for divide.
    logic [WIDTH-1:0]   m_q, m_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;     // product / quotient negate
    logic               rneg_q, rneg_d;   // remainder negate
    logic               dz_q, dz_d;       // divisor was zero
    logic [WIDTH-1:0]   araw_q, araw_d;   // raw dividend, returned in HI on divide-by-zero
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    // Operand conditioning for a new command.
    logic             op_signed;
    logic [WIDTH-1:0] abs_a, abs_b;

    assign op_signed = ~bus.op[0];
    assign abs_a     = (op_signed && bus.srca[WIDTH-1]) ? -bus.srca : bus.srca;
    assign abs_b     = (op_signed && bus.srcb[WIDTH-1]) ? -bus.srcb : bus.srcb;

    // Multiply step: conditionally add the multiplicand into the upper half,
    // then shift the whole pair right; the carry lands in the top bit.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    assign mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, (p_q[0] ? m_q : {WIDTH{1'b0}})};
    assign mul_next = {mul_sum, p_q[WIDTH-1:1]};

    // Divide step: shift {rem, quo} left one bit, trial-subtract the divisor.
    // The remainder is always below the divisor, so the shifted value fits in WIDTH+1 bits.
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;

    assign div_shift = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, m_q};
    assign div_next  = div_diff[WIDTH]
                     ? {div_shift[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0}
                     : {div_diff[WIDTH-1:0],  p_q[WIDTH-2:0], 1'b1};

    // Sign-corrected results, consumed in FINISH.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign prod_fix = neg_q  ? -p_q : p_q;
    assign quo_fix  = neg_q  ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
    assign rem_fix  = rneg_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        m_d      = m_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        araw_d   = araw_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.flush) begin
                    case (bus.op)
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            state_d  = S_CALC;
                            cnt_d    = CW'(WIDTH);
                            is_div_d = bus.op[1];
                            m_d      = bus.op[1] ? abs_b : abs_a;
                            p_d      = {{WIDTH{1'b0}}, (bus.op[1] ? abs_a : abs_b)};
                            neg_d    = op_signed & (bus.srca[WIDTH-1] ^ bus.srcb[WIDTH-1]);
                            rneg_d   = op_signed & bus.srca[WIDTH-1];
                            dz_d     = (bus.srcb == {WIDTH{1'b0}});
                            araw_d   = bus.srca;
                        end
                        3'd4:    hi_d = bus.srca;
                        3'd5:    lo_d = bus.srca;
                        default: ;
                    endcase
                end
            end
            S_CALC: begin
                cnt_d = cnt_q - CW'(1);
                p_d   = is_div_q ? div_next : mul_next;
                if (cnt_q == CW'(1)) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (dz_q) begin
                    hi_d = araw_q;
                    lo_d = {WIDTH{1'b1}};
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Flush wins over everything: abandon the op and keep HI/LO as they are.
        if (bus.flush) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            p_q      <= '0;
            m_q      <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            araw_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            m_q      <= m_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            araw_q   <= araw_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    // busy covers the iteration cycles; the FINISH cycle only commits the result.
    assign bus.busy = (state_q == S_CALC);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - directed self-checking bench for muldiv_seq
module tb_muldiv_seq;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    muldiv_seq_if #(.WIDTH(32)) bus ();

    muldiv_seq #(.WIDTH(32)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue a muldiv op (called #1 after an edge); returns #1 after the done edge.
    // inject >= 0 pulses a MULTU 5x5 start that many edges into the op.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input int inject);
        int edges;
        int busy_cnt;
        bus.start = 1'b1;
        bus.op    = op;
        bus.srca  = a;
        bus.srcb  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        edges     = 0;
        busy_cnt  = 0;
        if (bus.busy) busy_cnt++;
        while (edges < 100) begin
            if (edges == inject) begin
                bus.start = 1'b1;
                bus.op    = 3'd1;
                bus.srca  = 32'd5;
                bus.srcb  = 32'd5;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            edges++;
            #1;
            if (bus.done) break;
            if (bus.busy) busy_cnt++;
        end
        bus.start = 1'b0;
        check({tag, "_latency"}, 64'(edges), 64'd33);
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd32);
        check({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
        check({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
    endtask

    // Single-cycle MTHI/MTLO/no-op command, called #1 after an edge.
    task automatic quick_op(input logic [2:0] op, input logic [31:0] a, input logic fl);
        bus.start = 1'b1;
        bus.op    = op;
        bus.srca  = a;
        bus.srcb  = 32'd0;
        bus.flush = fl;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.srca  = 32'd0;
        bus.srcb  = 32'd0;
        bus.flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_hi", 64'(bus.hi), 64'd0);
        check("reset_lo", 64'(bus.lo), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Case 1: signed multiply, done pulse lasts one cycle
        run_op("mult_m3x5", 3'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, -1);
        @(posedge clk);
        #1;
        check("mult_done_pulse_width", 64'(bus.done), 64'd0);

        // Case 2: unsigned vs signed all-ones
        run_op("multu_ff", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, -1);
        run_op("mult_ff",  3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, -1);

        // Case 3: division signs and overflow
        run_op("div_m7_2",  3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, -1);
        run_op("divu_7_2",  3'd3, 32'd7, 32'd2, 32'd1, 32'd3, -1);
        run_op("div_7_m2",  3'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, -1);
        run_op("div_ovf",   3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, -1);

        // Case 4: divide by zero
        run_op("divu_by0", 3'd3, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, -1);
        run_op("div_by0",  3'd2, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, -1);

        // Case 5: MTHI/MTLO seeding, no-op, flush
        quick_op(3'd4, 32'h0000_1234, 1'b0);
        check("mthi_busy", 64'(bus.busy), 64'd0);
        check("mthi_done", 64'(bus.done), 64'd0);
        check("mthi_hi", 64'(bus.hi), 64'h1234);
        quick_op(3'd5, 32'h0000_5678, 1'b0);
        check("mtlo_busy", 64'(bus.busy), 64'd0);
        check("mtlo_lo", 64'(bus.lo), 64'h5678);
        quick_op(3'd6, 32'hDEAD_BEEF, 1'b0);
        check("nop_busy", 64'(bus.busy), 64'd0);
        check("nop_hi", 64'(bus.hi), 64'h1234);
        check("nop_lo", 64'(bus.lo), 64'h5678);
        quick_op(3'd4, 32'hDEAD_BEEF, 1'b1);
        check("flush_drops_mthi", 64'(bus.hi), 64'h1234);

        bus.start = 1'b1;
        bus.op    = 3'd0;
        bus.srca  = 32'd3;
        bus.srcb  = 32'd4;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("flush_pre_busy", 64'(bus.busy), 64'd1);
        repeat (9) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("flush_busy", 64'(bus.busy), 64'd0);
        check("flush_done", 64'(bus.done), 64'd0);
        check("flush_hi", 64'(bus.hi), 64'h1234);
        check("flush_lo", 64'(bus.lo), 64'h5678);
        run_op("after_flush", 3'd1, 32'd3, 32'd4, 32'd0, 32'd12, -1);

        // Async reset mid-CALC clears outputs before the next edge
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.op    = 3'd1;
        bus.srca  = 32'd9;
        bus.srcb  = 32'd9;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("areset_busy", 64'(bus.busy), 64'd0);
        check("areset_done", 64'(bus.done), 64'd0);
        check("areset_hi", 64'(bus.hi), 64'd0);
        check("areset_lo", 64'(bus.lo), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Case 6: start while busy ignored; back-to-back start in done cycle
        run_op("busy_ignore", 3'd1, 32'd7, 32'd6, 32'd0, 32'd42, 5);
        run_op("b2b_divu", 3'd3, 32'd9, 32'd3, 32'd0, 32'd3, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
